// File: rtl/lsu_axi_slv_mem.sv
// Single-beat AXI slave memory for the LSU port.
// Independent AW/W holding registers; fixed-latency read FSM.
module lsu_axi_slv_mem #(
    parameter int          TAG        = 3,
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [31:0] BASE       = 32'h0000_0000,
    parameter int          RD_LAT     = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           lsu_axi_awvalid,
    output logic           lsu_axi_awready,
    input  logic [TAG-1:0] lsu_axi_awid,
    input  logic [31:0]    lsu_axi_awaddr,
    input  logic [7:0]     lsu_axi_awlen,
    input  logic [2:0]     lsu_axi_awsize,
    input  logic           lsu_axi_wvalid,
    output logic           lsu_axi_wready,
    input  logic [63:0]    lsu_axi_wdata,
    input  logic [7:0]     lsu_axi_wstrb,
    input  logic           lsu_axi_wlast,
    output logic           lsu_axi_bvalid,
    input  logic           lsu_axi_bready,
    output logic [1:0]     lsu_axi_bresp,
    output logic [TAG-1:0] lsu_axi_bid,
    input  logic           lsu_axi_arvalid,
    output logic           lsu_axi_arready,
    input  logic [TAG-1:0] lsu_axi_arid,
    input  logic [31:0]    lsu_axi_araddr,
    input  logic [7:0]     lsu_axi_arlen,
    input  logic [2:0]     lsu_axi_arsize,
    output logic           lsu_axi_rvalid,
    input  logic           lsu_axi_rready,
    output logic [TAG-1:0] lsu_axi_rid,
    output logic [63:0]    lsu_axi_rdata,
    output logic [1:0]     lsu_axi_rresp,
    output logic           lsu_axi_rlast
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int HI    = DEPTH_LOG2 + 3;
    localparam int CW    = $clog2(RD_LAT + 1);
    localparam logic [31-HI:0] BASE_TAG = BASE[31:HI];

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    function automatic logic is_legal(input logic [31:0] a,
                                      input logic [7:0]  len,
                                      input logic [2:0]  size);
        return (a[31:HI] == BASE_TAG) && (len == 8'd0) && (size <= 3'd3);
    endfunction

    logic [63:0]           mem_q [DEPTH];

    logic                  aw_full_q;
    logic                  aw_legal_q;
    logic [DEPTH_LOG2-1:0] aw_idx_q;
    logic [TAG-1:0]        awid_q;
    logic                  w_full_q;
    logic [63:0]           wdata_q;
    logic [7:0]            wstrb_q;
    logic                  bvalid_q;
    logic [TAG-1:0]        bid_q;
    logic [1:0]            bresp_q;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q;
    logic                  r_legal_q;
    logic [DEPTH_LOG2-1:0] r_idx_q;
    logic [TAG-1:0]        rid_q;
    logic [63:0]           rdata_q;
    logic [1:0]            rresp_q;

    logic aw_hs, w_hs, ar_hs, commit;
    logic unused_bits;

    assign unused_bits = ^{lsu_axi_awaddr[2:0], lsu_axi_araddr[2:0],
                           lsu_axi_wlast};

    assign lsu_axi_awready = !aw_full_q & !rst;
    assign lsu_axi_wready  = !w_full_q & !rst;
    assign lsu_axi_arready = (state_q == S_IDLE) & !rst;

    assign aw_hs  = lsu_axi_awvalid & lsu_axi_awready;
    assign w_hs   = lsu_axi_wvalid & lsu_axi_wready;
    assign ar_hs  = lsu_axi_arvalid & lsu_axi_arready;
    assign commit = aw_full_q & w_full_q & !bvalid_q & !rst;

    // Array is deliberately excluded from reset so data survives it.
    always_ff @(posedge clk) begin
        if (commit && aw_legal_q) begin
            for (int i = 0; i < 8; i++) begin
                if (wstrb_q[i])
                    mem_q[aw_idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full_q  <= 1'b0;
            aw_legal_q <= 1'b0;
            aw_idx_q   <= '0;
            awid_q     <= '0;
            w_full_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= 2'b00;
        end else begin
            if (commit) begin
                aw_full_q <= 1'b0;
                w_full_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bid_q     <= awid_q;
                bresp_q   <= aw_legal_q ? 2'b00 : 2'b10;
            end else if (bvalid_q && lsu_axi_bready) begin
                bvalid_q <= 1'b0;
            end
            if (aw_hs) begin
                aw_full_q  <= 1'b1;
                aw_legal_q <= is_legal(lsu_axi_awaddr, lsu_axi_awlen,
                                       lsu_axi_awsize);
                aw_idx_q   <= lsu_axi_awaddr[HI-1:3];
                awid_q     <= lsu_axi_awid;
            end
            if (w_hs) begin
                w_full_q <= 1'b1;
                wdata_q  <= lsu_axi_wdata;
                wstrb_q  <= lsu_axi_wstrb;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (ar_hs) state_d = S_WAIT;
            S_WAIT: if (cnt_q == '0) state_d = S_RESP;
            S_RESP: if (lsu_axi_rready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            r_legal_q <= 1'b0;
            r_idx_q   <= '0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            if (ar_hs) begin
                rid_q     <= lsu_axi_arid;
                r_idx_q   <= lsu_axi_araddr[HI-1:3];
                r_legal_q <= is_legal(lsu_axi_araddr, lsu_axi_arlen,
                                      lsu_axi_arsize);
                cnt_q     <= CW'(RD_LAT - 1);
            end
            if (state_q == S_WAIT) begin
                if (cnt_q == '0) begin
                    rdata_q <= r_legal_q ? mem_q[r_idx_q] : 64'd0;
                    rresp_q <= r_legal_q ? 2'b00 : 2'b10;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    assign lsu_axi_bvalid = bvalid_q;
    assign lsu_axi_bid    = bid_q;
    assign lsu_axi_bresp  = bresp_q;
    assign lsu_axi_rvalid = (state_q == S_RESP);
    assign lsu_axi_rlast  = (state_q == S_RESP);
    assign lsu_axi_rid    = rid_q;
    assign lsu_axi_rdata  = rdata_q;
    assign lsu_axi_rresp  = rresp_q;

endmodule

// File: tb/tb_lsu_axi_slv_mem.sv
// Directed vector bench for lsu_axi_slv_mem.
// Table of single transactions plus hand sequences for timing corners.
module tb_lsu_axi_slv_mem;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid, awready;
    logic [2:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic        wvalid, wready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic [2:0]  bid;
    logic        arvalid, arready;
    logic [2:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        rvalid, rready;
    logic [2:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_axi_slv_mem #(
        .TAG(3), .DEPTH_LOG2(8), .BASE(32'h0), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .lsu_axi_awvalid(awvalid), .lsu_axi_awready(awready),
        .lsu_axi_awid(awid), .lsu_axi_awaddr(awaddr),
        .lsu_axi_awlen(awlen), .lsu_axi_awsize(awsize),
        .lsu_axi_wvalid(wvalid), .lsu_axi_wready(wready),
        .lsu_axi_wdata(wdata), .lsu_axi_wstrb(wstrb),
        .lsu_axi_wlast(wlast),
        .lsu_axi_bvalid(bvalid), .lsu_axi_bready(bready),
        .lsu_axi_bresp(bresp), .lsu_axi_bid(bid),
        .lsu_axi_arvalid(arvalid), .lsu_axi_arready(arready),
        .lsu_axi_arid(arid), .lsu_axi_araddr(araddr),
        .lsu_axi_arlen(arlen), .lsu_axi_arsize(arsize),
        .lsu_axi_rvalid(rvalid), .lsu_axi_rready(rready),
        .lsu_axi_rid(rid), .lsu_axi_rdata(rdata),
        .lsu_axi_rresp(rresp), .lsu_axi_rlast(rlast)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  id;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [1:0]  resp;
    } vec_t;

    localparam int NV = 18;
    vec_t tv [NV];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic aw_send(input logic [31:0] a, input logic [2:0] id,
                           input logic [7:0] len, input logic [2:0] sz);
        bit ok = 0;
        awvalid = 1; awaddr = a; awid = id; awlen = len; awsize = sz;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (awready) begin ok = 1; break; end
        end
        chk("aw_accept", 64'(ok), 64'd1);
        @(posedge clk); #1;
        awvalid = 0;
    endtask

    task automatic w_send(input logic [63:0] d, input logic [7:0] s);
        bit ok = 0;
        wvalid = 1; wdata = d; wstrb = s; wlast = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wready) begin ok = 1; break; end
        end
        chk("w_accept", 64'(ok), 64'd1);
        @(posedge clk); #1;
        wvalid = 0;
    endtask

    task automatic ar_send(input logic [31:0] a, input logic [2:0] id,
                           input logic [7:0] len, input logic [2:0] sz);
        bit ok = 0;
        arvalid = 1; araddr = a; arid = id; arlen = len; arsize = sz;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (arready) begin ok = 1; break; end
        end
        chk("ar_accept", 64'(ok), 64'd1);
        @(posedge clk); #1;
        arvalid = 0;
    endtask

    task automatic wait_b(input logic [2:0] id, input logic [1:0] rs);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bvalid) begin ok = 1; break; end
        end
        chk("bvalid_seen", 64'(ok), 64'd1);
        chk("bid", 64'(bid), 64'(id));
        chk("bresp", 64'(bresp), 64'(rs));
        @(posedge clk); #1;
    endtask

    task automatic wait_r(input logic [2:0] id, input logic [63:0] d,
                          input logic [1:0] rs);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rvalid) begin ok = 1; break; end
        end
        chk("rvalid_seen", 64'(ok), 64'd1);
        chk("rid", 64'(rid), 64'(id));
        chk("rdata", rdata, d);
        chk("rresp", 64'(rresp), 64'(rs));
        chk("rlast", 64'(rlast), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [2:0] id,
                            input logic [7:0] len, input logic [2:0] sz,
                            input logic [63:0] d, input logic [7:0] s);
        fork
            aw_send(a, id, len, sz);
            w_send(d, s);
        join
    endtask

    initial begin
        int     lat;
        bit     ok;
        time    t0;
        logic [63:0] d1, d2;

        tv[0]  = '{1, 32'h10, 3'd1, 8'd0, 3'd3, 64'h1122334455667788, 8'hFF, 2'b00};
        tv[1]  = '{0, 32'h10, 3'd2, 8'd0, 3'd3, 64'h1122334455667788, 8'h00, 2'b00};
        tv[2]  = '{1, 32'h20, 3'd3, 8'd0, 3'd3, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 2'b00};
        tv[3]  = '{1, 32'h20, 3'd4, 8'd0, 3'd3, 64'h0, 8'h0F, 2'b00};
        tv[4]  = '{0, 32'h20, 3'd5, 8'd0, 3'd3, 64'hFFFFFFFF00000000, 8'h00, 2'b00};
        tv[5]  = '{1, 32'h0, 3'd6, 8'd0, 3'd3, 64'h0123456789ABCDEF, 8'hFF, 2'b00};
        tv[6]  = '{1, 32'h800, 3'd7, 8'd0, 3'd3, 64'hAAAAAAAAAAAAAAAA, 8'hFF, 2'b10};
        tv[7]  = '{0, 32'h0, 3'd0, 8'd0, 3'd3, 64'h0123456789ABCDEF, 8'h00, 2'b00};
        tv[8]  = '{0, 32'h10, 3'd1, 8'd1, 3'd3, 64'h0, 8'h00, 2'b10};
        tv[9]  = '{1, 32'h10, 3'd2, 8'd0, 3'd4, 64'h0, 8'hFF, 2'b10};
        tv[10] = '{1, 32'h10, 3'd3, 8'd2, 3'd3, 64'h0, 8'hFF, 2'b10};
        tv[11] = '{0, 32'h13, 3'd4, 8'd0, 3'd2, 64'h1122334455667788, 8'h00, 2'b00};
        tv[12] = '{0, 32'h10000010, 3'd5, 8'd0, 3'd3, 64'h0, 8'h00, 2'b10};
        tv[13] = '{1, 32'h28, 3'd6, 8'd0, 3'd3, 64'h0, 8'hFF, 2'b00};
        tv[14] = '{1, 32'h28, 3'd7, 8'd0, 3'd3, 64'hFFFFFFFFFFFFFFFF, 8'h81, 2'b00};
        tv[15] = '{0, 32'h28, 3'd3, 8'd0, 3'd3, 64'hFF000000000000FF, 8'h00, 2'b00};
        tv[16] = '{1, 32'h7F8, 3'd1, 8'd0, 3'd3, 64'h5555666677778888, 8'hFF, 2'b00};
        tv[17] = '{0, 32'h7F8, 3'd2, 8'd0, 3'd3, 64'h5555666677778888, 8'h00, 2'b00};

        rst = 1;
        awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0;
        arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0;
        bready = 1; rready = 1;

        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rlast", 64'(rlast), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_ids", 64'({bid, rid}), 64'd0);
        chk("rst_resps", 64'({bresp, rresp}), 64'd0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("post_rst_readys", 64'({awready, wready, arready}), 64'd7);
        @(posedge clk); #1;

        for (int v = 0; v < NV; v++) begin
            if (tv[v].wr) begin
                do_write(tv[v].addr, tv[v].id, tv[v].len, tv[v].size,
                         tv[v].data, tv[v].strb);
                wait_b(tv[v].id, tv[v].resp);
            end else begin
                ar_send(tv[v].addr, tv[v].id, tv[v].len, tv[v].size);
                wait_r(tv[v].id, tv[v].data, tv[v].resp);
            end
        end

        // read latency and back-to-back spacing
        ar_send(32'h10, 3'd2, 8'd0, 3'd3);
        t0 = $time;
        lat = 0; ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (rvalid) begin ok = 1; break; end
        end
        chk("rd_latency", 64'(lat), 64'(RD_LAT + 1));
        chk("lat_rdata", rdata, 64'h1122334455667788);
        @(posedge clk); #1;
        ar_send(32'h20, 3'd3, 8'd0, 3'd3);
        chk("b2b_spacing", 64'(($time - t0) / 10), 64'(RD_LAT + 2));
        wait_r(3'd3, 64'hFFFFFFFF00000000, 2'b00);

        // W three cycles ahead of AW
        w_send(64'hCAFEBABE12345678, 8'hFF);
        @(negedge clk);
        chk("w_first_wready", 64'(wready), 64'd0);
        chk("w_first_nob", 64'(bvalid), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        aw_send(32'h40, 3'd2, 8'd0, 3'd3);
        @(negedge clk);
        chk("aw_late_b0", 64'(bvalid), 64'd0);
        wait_b(3'd2, 2'b00);
        ar_send(32'h40, 3'd6, 8'd0, 3'd3);
        wait_r(3'd6, 64'hCAFEBABE12345678, 2'b00);

        // B backpressure with a second write queued behind it
        d1 = 64'h3030303030303030;
        d2 = 64'h3838383838383838;
        bready = 0;
        do_write(32'h30, 3'd5, 8'd0, 3'd3, d1, 8'hFF);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bvalid) begin ok = 1; break; end
        end
        chk("bp_bvalid_seen", 64'(ok), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_b_stable", 64'({bvalid, bid, bresp}), {61'd0, 1'b1, 3'd5} << 2);
            @(negedge clk);
        end
        @(posedge clk); #1;
        do_write(32'h38, 3'd6, 8'd0, 3'd3, d2, 8'hFF);
        @(negedge clk);
        chk("bp_aw_held", 64'(awready), 64'd0);
        chk("bp_b_still", 64'({bvalid, bid}), 64'({1'b1, 3'd5}));
        @(posedge clk); #1;
        bready = 1;
        wait_b(3'd5, 2'b00);
        wait_b(3'd6, 2'b00);

        // R backpressure; second AR stalls until R handshake
        rready = 0;
        ar_send(32'h30, 3'd3, 8'd0, 3'd3);
        arvalid = 1; araddr = 32'h38; arid = 3'd4; arlen = 0; arsize = 3;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rvalid) begin ok = 1; break; end
        end
        chk("rp_rvalid_seen", 64'(ok), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("rp_rdata_stable", rdata, d1);
            chk("rp_rid_stable", 64'({rvalid, rid, rresp}), 64'({1'b1, 3'd3, 2'b00}));
            chk("rp_ar_blocked", 64'(arready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rready = 1;
        @(posedge clk); #1;
        ar_send(32'h38, 3'd4, 8'd0, 3'd3);
        wait_r(3'd4, d2, 2'b00);

        // reset during read WAIT with B pending
        bready = 0;
        do_write(32'h48, 3'd3, 8'd0, 3'd3, 64'h4848484848484848, 8'hFF);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bvalid) begin ok = 1; break; end
        end
        chk("rst_seq_bvalid", 64'(ok), 64'd1);
        @(posedge clk); #1;
        ar_send(32'h30, 3'd1, 8'd0, 3'd3);
        rst = 1;
        @(negedge clk);
        chk("rst_hi_readys", 64'({awready, wready, arready}), 64'd0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst_mid_rvalid", 64'(rvalid), 64'd0);
        chk("rst_mid_bvalid", 64'(bvalid), 64'd0);
        chk("rst_mid_arready", 64'(arready), 64'd1);
        @(posedge clk); #1;
        bready = 1;
        ar_send(32'h30, 3'd1, 8'd0, 3'd3);
        wait_r(3'd1, d1, 2'b00);
        ar_send(32'h48, 3'd2, 8'd0, 3'd3);
        wait_r(3'd2, 64'h4848484848484848, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
